// File: rtl/pingpang_unpack.sv
// ----------------------------------------------------------------------------
// pingpang_unpack
//   Write-wide / read-narrow ping-pong buffer in a single clock domain.
//   16-bit words fill one of two banks while the other, closed bank drains
//   as 8-bit bytes, low byte first. Banks are closed and drained strictly in
//   the order 0,1,0,1...
//
// Optional feature (macro PP_FLUSH_EN):
//   Adds the 'flush' input, which closes a partially filled write bank early.
//   The reader then drains only the words that were actually written.
//   With the macro undefined, banks close only when full.
//
// Ports:
//   sys_clk    in   1   clock, rising edge
//   sys_rst    in   1   asynchronous reset, active-high
//   flush      in   1   close partial write bank early (PP_FLUSH_EN only)
//   in_valid   in   1   in_data valid
//   in_data    in   16  input word
//   in_ready   out  1   write bank can take a word (comb from registered flags)
//   out_valid  out  1   out_data valid
//   out_data   out  8   output byte
//   out_ready  in   1   consumer accepts byte
//   bank_full  out  2   bit i = bank i closed, waiting to drain or draining
// ----------------------------------------------------------------------------
module pingpang_unpack #(
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned AW         = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
`ifdef PP_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [1:0]  bank_full
);

  // Fill count needs one more bit than the word pointer to hold BANK_DEPTH.
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(BANK_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BANK_DEPTH);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LOAD = 2'd1,
    R_LO   = 2'd2,
    R_HI   = 2'd3
  } rd_state_e;

  // Storage and state
  logic [15:0]   mem_q [2][BANK_DEPTH];
  logic [1:0]    bank_full_q;
  logic          wr_sel_q;
  logic [AW-1:0] wr_ptr_q;
  rd_state_e     rd_state_q;
  logic          rd_sel_q;
  logic [AW-1:0] rd_ptr_q;
  logic [15:0]   word_q;
  logic          out_valid_q;
  logic [7:0]    out_data_q;

  // Combinational helpers
  logic          in_ready_c;
  logic          wr_fire_c;
  logic          wr_last_c;
  logic          wr_close_c;
  logic [CW-1:0] rd_cnt_c;
  logic          rd_last_c;
  logic          rd_release_c;
  logic [15:0]   rd_word_c;
  logic [15:0]   rd_next_c;
  logic [1:0]    bank_set_c;
  logic [1:0]    bank_clr_c;

  // Write side handshake: only the current write bank's flag gates input.
  assign in_ready_c = !bank_full_q[wr_sel_q];
  assign wr_fire_c  = in_valid && in_ready_c;
  assign wr_last_c  = wr_fire_c && (wr_ptr_q == LAST_PTR);

`ifdef PP_FLUSH_EN
  logic [1:0][CW-1:0] cnt_q;
  logic [CW-1:0]      flush_cnt_c;
  logic               flush_close_c;

  // A word accepted alongside flush is written first and counted; a flush
  // with nothing written (and nothing arriving) is ignored.
  assign flush_cnt_c   = CW'(wr_ptr_q) + CW'(wr_fire_c);
  assign flush_close_c = flush && !wr_last_c && (flush_cnt_c != '0);
  assign wr_close_c    = wr_last_c || flush_close_c;

  // Per-bank fill count; on a normal close flush_cnt_c equals BANK_DEPTH.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '{default: FULL_CNT};
    end else if (wr_close_c) begin
      cnt_q[wr_sel_q] <= flush_cnt_c;
    end
  end

  assign rd_cnt_c = cnt_q[rd_sel_q];
`else
  assign wr_close_c = wr_last_c;
  assign rd_cnt_c   = FULL_CNT;
`endif

  // Bank storage; no reset needed, contents are only read from closed banks.
  always_ff @(posedge sys_clk) begin
    if (wr_fire_c) begin
      mem_q[wr_sel_q][wr_ptr_q] <= in_data;
    end
  end

  // Write pointer and bank select.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      wr_sel_q <= 1'b0;
    end else if (wr_close_c) begin
      wr_ptr_q <= '0;
      wr_sel_q <= !wr_sel_q;
    end else if (wr_fire_c) begin
      wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end

  // Read side helpers; prefetch index may wrap past the last word, but that
  // value is never presented because the bank is released first.
  assign rd_word_c    = mem_q[rd_sel_q][rd_ptr_q];
  assign rd_next_c    = mem_q[rd_sel_q][rd_ptr_q + AW'(1)];
  assign rd_last_c    = ((CW'(rd_ptr_q) + CW'(1)) == rd_cnt_c);
  assign rd_release_c = (rd_state_q == R_HI) && out_ready && rd_last_c;

  // Writer only sets the write bank, reader only clears the read bank; both
  // may happen on one edge and never target the same bank.
  assign bank_set_c = {wr_close_c && wr_sel_q,   wr_close_c && !wr_sel_q};
  assign bank_clr_c = {rd_release_c && rd_sel_q, rd_release_c && !rd_sel_q};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bank_full_q <= '0;
    end else begin
      bank_full_q <= (bank_full_q & ~bank_clr_c) | bank_set_c;
    end
  end

  // Read FSM: load word, emit low byte, emit high byte while prefetching.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_state_q  <= R_IDLE;
      rd_sel_q    <= 1'b0;
      rd_ptr_q    <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (bank_full_q[rd_sel_q]) begin
            rd_state_q <= R_LOAD;
          end
        end
        R_LOAD: begin
          word_q      <= rd_word_c;
          out_data_q  <= rd_word_c[7:0];
          out_valid_q <= 1'b1;
          rd_state_q  <= R_LO;
        end
        R_LO: begin
          if (out_ready) begin
            out_data_q <= word_q[15:8];
            word_q     <= rd_next_c;
            rd_state_q <= R_HI;
          end
        end
        R_HI: begin
          if (out_ready) begin
            if (rd_last_c) begin
              out_valid_q <= 1'b0;
              rd_sel_q    <= !rd_sel_q;
              rd_ptr_q    <= '0;
              rd_state_q  <= R_IDLE;
            end else begin
              out_data_q <= word_q[7:0];
              rd_ptr_q   <= rd_ptr_q + AW'(1);
              rd_state_q <= R_LO;
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign bank_full = bank_full_q;

endmodule

// File: tb/tb_pingpang_unpack.sv
// ----------------------------------------------------------------------------
// tb_pingpang_unpack
//   Scoreboard bench: every accepted word pushes its two bytes (low first)
//   into a queue; every accepted output byte is popped and compared. Stalled
//   output bytes must hold value. Directed checks cover reset, latency,
//   back-pressure, mid-drain reset and (with PP_FLUSH_EN) early bank close.
// ----------------------------------------------------------------------------
module tb_pingpang_unpack;

  logic        sys_clk;
  logic        sys_rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  bank_full;
`ifdef PP_FLUSH_EN
  logic        flush;
`endif

  pingpang_unpack #(.BANK_DEPTH(32), .AW(5)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
`ifdef PP_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .bank_full (bank_full)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       mon_en    = 1'b0;
  logic       rand_en   = 1'b0;
  logic       ready_fix = 1'b1;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sole driver of out_ready: fixed level or 50% random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Monitor/scoreboard; inputs only change at posedge+1, so what is seen here
  // is exactly what the next rising edge will act on.
  always @(negedge sys_clk) begin
    logic [8:0] exp;
    if (!mon_en) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data[7:0]);
        exp_q.push_back(in_data[15:8]);
      end
      if (out_valid && out_ready) begin
        exp = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
        check("byte", 32'({1'b0, out_data}), 32'(exp));
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer one word; returns #1 after the edge that accepted it.
  task automatic put(input logic [15:0] d, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge sys_clk);
    while (!in_ready && waits < 4000) begin
      @(negedge sys_clk);
      waits++;
    end
    if (!in_ready) check("put_ready", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge sys_clk);
    while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_bank_full", 32'(bank_full), 32'd0);
    tick();
    sys_rst = 1'b0;
    exp_q.delete();
    tick();
    mon_en = 1'b1;
  endtask

  initial begin
    int w;
    int n;
    sys_rst  = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef PP_FLUSH_EN
    flush    = 1'b0;
`endif
    repeat (2) tick();
    do_reset();

    // 1: one bank back-to-back, latency of first byte
    for (int i = 0; i < 32; i++) put(16'(16'h0100 + i), w);
    in_valid = 1'b0;
    @(negedge sys_clk);
    check("t1_lat_e0", 32'(out_valid), 32'd0);
    check("t1_bank_full", 32'(bank_full), 32'd1);
    @(negedge sys_clk);
    check("t1_lat_e1", 32'(out_valid), 32'd0);
    @(negedge sys_clk);
    check("t1_lat_e2", 32'(out_valid), 32'd1);
    tick();
    drain("t1_drain");

    // 2: three banks, paced so the writer never waits
    for (int i = 0; i < 96; i++) begin
      put(16'(16'h2000 + i), w);
      check("t2_no_stall", 32'(w), 32'd0);
      in_valid = 1'b0;
      tick();
      tick();
    end
    drain("t2_drain");

    // 3: back-pressure fills both banks, word 65 held until bank 0 frees
    ready_fix = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 64; i++) put(16'(16'h3000 + i), w);
    in_valid = 1'b1;
    in_data  = 16'h3040;
    @(negedge sys_clk);
    check("t3_both_full", 32'(bank_full), 32'd3);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("t3_held", 32'(in_ready), 32'd0);
    end
    tick();
    ready_fix = 1'b1;
    n = 0;
    @(negedge sys_clk);
    while (bank_full[0] && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check("t3_release_ready", 32'(in_ready), 32'd1);
    check("t3_release_bf", 32'(bank_full), 32'd2);
    tick();
    for (int i = 65; i < 96; i++) put(16'(16'h3000 + i), w);
    in_valid = 1'b0;
    drain("t3_drain");

    // 4: random consumer stalls over a multi-bank stream
    rand_en = 1'b1;
    for (int i = 0; i < 96; i++) put(16'($urandom_range(0, 16'hffff)), w);
    in_valid = 1'b0;
    drain("t4_drain");
    rand_en = 1'b0;
    tick();

    // 5: reset in the middle of draining bank 0
    for (int i = 0; i < 32; i++) put(16'(16'h3300 + i), w);
    in_valid = 1'b0;
    n = 0;
    @(negedge sys_clk);
    while (exp_q.size() > 40 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    check("t5_mid_drain", 32'(out_valid), 32'd1);
    tick();
    do_reset();
    for (int i = 0; i < 32; i++) put(16'(16'h5A00 + 3 * i), w);
    in_valid = 1'b0;
    @(negedge sys_clk);
    check("t5_bank0", 32'(bank_full), 32'd1);
    tick();
    drain("t5_drain");

`ifdef PP_FLUSH_EN
    // 6: flush on empty bank is ignored; partial bank drains only its words
    do_reset();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge sys_clk);
    check("t6_empty_flush", 32'(bank_full), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) put(16'(16'hA0B0 + 16'h0101 * i), w);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    @(negedge sys_clk);
    check("t6_flush_bf", 32'(bank_full), 32'd1);
    check("t6_flush_q", 32'(exp_q.size()), 32'd10);
    tick();
    drain("t6_drain");
    check("t6_released", 32'(bank_full), 32'd0);
    for (int i = 0; i < 32; i++) put(16'(16'hC000 + i), w);
    in_valid = 1'b0;
    @(negedge sys_clk);
    check("t6_bank1", 32'(bank_full), 32'd2);
    tick();
    drain("t6_drain2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
